// File: rtl/music_pkg.sv
// Shared types and note-entry layout for the music sequencer.
// A ROM word is {duration[11:0], period[19:0]}; zero duration marks end of song.
package music_pkg;

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, PLAY, GAP, ADVANCE} state_t;

    localparam int DUR_MSB = 31;
    localparam int DUR_LSB = 20;
    localparam int DUR_W   = DUR_MSB - DUR_LSB + 1;
    localparam int PER_W   = 20;

    localparam logic [31:0] END_WORD = 32'h0000_0000;

    typedef struct packed {
        logic [DUR_W-1:0] dur;
        logic [PER_W-1:0] per;
    } note_t;

    // A pitched entry with no duration would never finish, so it also ends the song.
    function automatic logic is_end(input note_t n);
        return (32'(n) == END_WORD) || (n.dur == '0);
    endfunction

endpackage

// File: rtl/music_seq_if.sv
// Control, note-ROM and pwm_gen signals of the music sequencer.
// master = game control / ROM / pwm_gen side, slave = sequencer.
interface music_seq_if #(
    parameter int ADDR_W = 9
);
    logic              start;
    logic              stop;
    logic              pause;
    logic              loop;
    logic [1:0]        song_sel;
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       rom_data;
    logic [31:0]       counter_arr;
    logic [31:0]       counter_crr;
    logic              pwm_en;
    logic              busy;
    logic              done;
    logic [ADDR_W-3:0] note_idx;

    modport master (
        output start, stop, pause, loop, song_sel, rom_data,
        input  rom_addr, counter_arr, counter_crr, pwm_en, busy, done, note_idx
    );

    modport slave (
        input  start, stop, pause, loop, song_sel, rom_data,
        output rom_addr, counter_arr, counter_crr, pwm_en, busy, done, note_idx
    );
endinterface

// File: rtl/music_seq_tick_gen.sv
// Duration time-base prescaler: one-cycle tick every DIV enabled cycles.
// clr restarts the count so each note/gap starts on a full tick period.
module tick_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == CW'(DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)          cnt <= '0;
        else if (clr || tick)  cnt <= '0;
        else if (en)           cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/music_seq.sv
// Note sequencer: walks a song in the note ROM and programs pwm_gen
// with each note's period for its duration, followed by a silent gap.
module music_seq
    import music_pkg::*;
#(
    parameter int CLK_HZ    = 100000000,
    parameter int TICK_HZ   = 1000,
    parameter int ADDR_W    = 9,
    parameter int GAP_TICKS = 10
) (
    input logic        clk,
    input logic        reset_n,
    music_seq_if.slave bus
);
    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int IDX_W    = ADDR_W - 2;

    if (TICK_DIV < 2) begin : g_bad_div
        $error("music_seq: CLK_HZ/TICK_HZ must be at least 2");
    end

    state_t            state, state_nx;
    logic [ADDR_W-1:0] base_q, addr_q, song_base;
    logic [IDX_W-1:0]  idx_q;
    logic [DUR_W-1:0]  cnt_q;
    logic [31:0]       arr_q;
    logic              done_q, busy, timing, tick, last_tick, note_end, idx_last;
    note_t             note;

    assign note      = note_t'(bus.rom_data);
    assign note_end  = is_end(note);
    assign song_base = {bus.song_sel, {IDX_W{1'b0}}};
    assign busy      = (state != IDLE);
    assign timing    = (state == PLAY) || (state == GAP);
    assign last_tick = tick && (cnt_q == DUR_W'(1));
    assign idx_last  = (idx_q == '1);

    tick_gen #(.DIV(TICK_DIV)) u_tick (
        .clk    (clk),
        .reset_n(reset_n),
        .clr    (!timing),
        .en     (timing && !bus.pause),
        .tick   (tick)
    );

    assign bus.rom_addr    = addr_q;
    assign bus.note_idx    = idx_q;
    assign bus.counter_arr = arr_q;
    assign bus.counter_crr = {1'b0, arr_q[31:1]};
    assign bus.pwm_en      = (state == PLAY) && (arr_q != '0) && !bus.pause;
    assign bus.busy        = busy;
    assign bus.done        = done_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            FETCH:   state_nx = WAIT;
            WAIT:    state_nx = note_end ? (bus.loop ? FETCH : IDLE) : PLAY;
            PLAY:    if (last_tick) state_nx = (GAP_TICKS > 0) ? GAP : ADVANCE;
            GAP:     if (last_tick) state_nx = ADVANCE;
            ADVANCE: state_nx = (idx_last && !bus.loop) ? IDLE : FETCH;
            default: state_nx = state;
        endcase
        // stop beats start; start from any state (re)launches the selected song
        if (bus.stop)       state_nx = IDLE;
        else if (bus.start) state_nx = FETCH;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_q <= '0;
            addr_q <= '0;
            idx_q  <= '0;
            cnt_q  <= '0;
            arr_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.stop) begin
                if (busy) begin
                    arr_q  <= '0;
                    done_q <= 1'b1;
                end
            end else if (bus.start) begin
                base_q <= song_base;
                addr_q <= song_base;
                idx_q  <= '0;
            end else begin
                case (state)
                    WAIT: begin
                        if (!note_end) begin
                            arr_q <= 32'(note.per);
                            cnt_q <= note.dur;
                        end else if (bus.loop) begin
                            addr_q <= base_q;
                            idx_q  <= '0;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                    PLAY, GAP: begin
                        if (last_tick && state == PLAY) cnt_q <= DUR_W'(GAP_TICKS);
                        else if (tick)                  cnt_q <= cnt_q - 1'b1;
                    end
                    ADVANCE: begin
                        if (idx_last && bus.loop) begin
                            addr_q <= base_q;
                            idx_q  <= '0;
                        end else begin
                            addr_q <= addr_q + 1'b1;
                            idx_q  <= idx_q + 1'b1;
                            done_q <= idx_last;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_music_seq.sv
// Self-checking bench for music_seq: a timeline model expands each song into
// phases and a monitor compares every cycle's outputs against the queue.
module tb_music_seq;
    import music_pkg::*;

    localparam int CLK_HZ = 1000, TICK_HZ = 100, ADDR_W = 9, GAP_TICKS = 1;
    localparam int TD = CLK_HZ / TICK_HZ;
    localparam int NS = 1 << (ADDR_W - 2);
    localparam int AMOD = 1 << ADDR_W;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    music_seq_if #(.ADDR_W(ADDR_W)) bus ();

    music_seq #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .ADDR_W(ADDR_W), .GAP_TICKS(GAP_TICKS)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    logic [31:0] rom [0:AMOD-1];
    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    typedef struct {
        bit pwm; int unsigned arr; int unsigned addr; int unsigned idx; bit busy; bit done;
    } exp_t;

    typedef struct {
        int len; bit frz; bit pwm; int unsigned arr; int unsigned addr; int unsigned idx;
        bit is_end; int unsigned paddr; int unsigned pidx;
    } ph_t;

    exp_t q[$];
    ph_t  ph[$];
    ph_t  cur;
    bit   m_busy, m_done;
    int unsigned m_arr, m_addr, m_idx, m_base;
    int n_vec = 0, n_bad = 0;

    // Expand a song into its timeline: fetch, check, play, gap, advance per note.
    function automatic void gen(int unsigned base, int unsigned arr0);
        int unsigned arr = arr0;
        for (int i = 0; i < NS; i++) begin
            int unsigned dur, per;
            ph_t p;
            dur = rom[base+i] >> 20;
            per = rom[base+i] & 32'h000F_FFFF;
            p = '{len:1, frz:0, pwm:0, arr:arr, addr:base+i, idx:i, is_end:0, paddr:0, pidx:0};
            ph.push_back(p);
            p.is_end = (dur == 0); p.paddr = base + i; p.pidx = i;
            ph.push_back(p);
            if (dur == 0) return;
            p = '{len:dur*TD, frz:1, pwm:(per != 0), arr:per, addr:base+i, idx:i, is_end:0, paddr:0, pidx:0};
            ph.push_back(p);
            if (GAP_TICKS > 0) begin
                p.len = GAP_TICKS * TD; p.pwm = 0;
                ph.push_back(p);
            end
            p = '{len:1, frz:0, pwm:0, arr:per, addr:base+i, idx:i, is_end:(i == NS-1),
                  paddr:(base+NS) % AMOD, pidx:0};
            ph.push_back(p);
            arr = per;
        end
    endfunction

    function automatic void model_reset();
        ph.delete();
        m_busy = 0; m_done = 0; m_arr = 0; m_addr = 0; m_idx = 0; m_base = 0;
    endfunction

    function automatic void step(bit st, bit sp, bit pa, bit lp, logic [1:0] sel);
        bit was_done = m_done;
        m_done = 0;
        if (sp) begin
            if (m_busy) begin
                m_done = 1; m_busy = 0; m_arr = 0; m_addr = cur.addr; m_idx = cur.idx;
            end
        end else if (st) begin
            int unsigned a = m_busy ? cur.arr : m_arr;
            ph.delete();
            m_base = int'(sel) * NS;
            gen(m_base, a);
            cur = ph.pop_front();
            m_busy = 1;
        end else if (m_busy) begin
            if (!(cur.frz && pa)) cur.len--;
            if (cur.len == 0) begin
                if (cur.is_end) begin
                    if (lp) begin
                        ph.delete(); gen(m_base, cur.arr); cur = ph.pop_front();
                    end else begin
                        m_busy = 0; m_done = 1; m_arr = cur.arr; m_addr = cur.paddr; m_idx = cur.pidx;
                    end
                end else begin
                    cur = ph.pop_front();
                end
            end
        end
        if (was_done && m_busy) m_done = 0;
    endfunction

    task automatic cyc(input bit st, input bit sp, input bit pa, input bit lp, input logic [1:0] sel);
        exp_t e;
        @(posedge clk); #1;
        bus.start = st; bus.stop = sp; bus.pause = pa; bus.loop = lp; bus.song_sel = sel;
        if (m_busy) e = '{pwm:cur.pwm && !pa, arr:cur.arr, addr:cur.addr, idx:cur.idx, busy:1, done:0};
        else        e = '{pwm:0, arr:m_arr, addr:m_addr, idx:m_idx, busy:0, done:m_done};
        q.push_back(e);
        step(st, sp, pa, lp, sel);
    endtask

    task automatic run(input int n, input bit lp, input logic [1:0] sel);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, lp, sel);
    endtask

    task automatic check_zero(input string name);
        n_vec++;
        if (bus.pwm_en !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.counter_arr !== 32'd0 ||
            bus.counter_crr !== 32'd0 || bus.rom_addr !== '0 || bus.note_idx !== '0) begin
            n_bad++;
            $display("FAIL %s: got pwm=%0b busy=%0b done=%0b arr=%0d crr=%0d addr=%0d idx=%0d, want all 0",
                     name, bus.pwm_en, bus.busy, bus.done, bus.counter_arr, bus.counter_crr,
                     bus.rom_addr, bus.note_idx);
        end
    endtask

    task automatic fill_song1();
        int n = $urandom_range(1, 5);
        for (int i = 0; i < NS; i++) rom[NS+i] = 32'd0;
        for (int i = 0; i < n; i++) begin
            logic [11:0] d;
            logic [19:0] p;
            d = 12'($urandom_range(1, 3));
            p = ($urandom_range(0, 3) == 0) ? 20'd0 : 20'($urandom);
            rom[NS+i] = {d, p};
        end
        if ($urandom_range(0, 1) == 1) rom[NS+n] = {12'd0, 20'($urandom_range(1, 1000))};
    endtask

    // Monitor: one comparison per cycle, sampled on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                n_vec++;
                if (bus.pwm_en !== e.pwm || bus.counter_arr !== e.arr || bus.counter_crr !== (e.arr >> 1) ||
                    bus.rom_addr !== ADDR_W'(e.addr) || bus.note_idx !== (ADDR_W-2)'(e.idx) ||
                    bus.busy !== e.busy || bus.done !== e.done) begin
                    n_bad++;
                    $display("FAIL cycle@%0t: got pwm=%0b arr=%0d crr=%0d addr=%0d idx=%0d busy=%0b done=%0b; want pwm=%0b arr=%0d crr=%0d addr=%0d idx=%0d busy=%0b done=%0b",
                             $time, bus.pwm_en, bus.counter_arr, bus.counter_crr, bus.rom_addr, bus.note_idx,
                             bus.busy, bus.done, e.pwm, e.arr, e.arr >> 1, e.addr, e.idx, e.busy, e.done);
                end
            end
        end
    end

    initial begin
        bus.start = 0; bus.stop = 0; bus.pause = 0; bus.loop = 0; bus.song_sel = 0;
        for (int i = 0; i < AMOD; i++) rom[i] = 32'd0;
        rom[0] = {12'd3, 20'd500};
        rom[1] = {12'd2, 20'd0};
        rom[256] = {12'd1, 20'd300};
        rom[257] = {12'd2, 20'd77};
        rom[258] = {12'd1, 20'd0};
        rom[259] = {12'd0, 20'd999};
        for (int i = 0; i < NS; i++) rom[3*NS+i] = {12'd1, 20'(100 + i)};
        model_reset();
        #2 check_zero("reset_state");
        run(3, 0, 0);
        reset_n = 1'b1;

        // basic song, no loop
        cyc(1, 0, 0, 0, 0); run(90, 0, 0);
        // looping, then stop
        cyc(1, 0, 0, 1, 0); run(200, 1, 0); cyc(0, 1, 0, 1, 0); run(5, 0, 0);
        // pause mid-note
        cyc(1, 0, 0, 0, 0); run(12, 0, 0);
        for (int i = 0; i < 7; i++) cyc(0, 0, 1, 0, 0);
        run(80, 0, 0);
        // stop in PLAY, then start+stop together from IDLE, stop in IDLE
        cyc(1, 0, 0, 0, 0); run(10, 0, 0); cyc(0, 1, 0, 0, 0); run(3, 0, 0);
        cyc(1, 1, 0, 0, 1); run(3, 0, 0); cyc(0, 1, 0, 0, 0); run(2, 0, 0);
        // song 2, song_sel changed mid-song
        cyc(1, 0, 0, 0, 2); run(5, 0, 2); run(100, 0, 1);
        // restart while busy
        cyc(1, 0, 0, 0, 0); run(15, 0, 0); cyc(1, 0, 0, 0, 2); run(100, 0, 0);
        // async reset in the gap of note 0
        cyc(1, 0, 0, 0, 0); run(37, 0, 0);
        @(posedge clk); #1;
        reset_n = 1'b0;
        model_reset();
        q.push_back('{pwm:0, arr:0, addr:0, idx:0, busy:0, done:0});
        #1 check_zero("async_reset");
        run(2, 0, 0);
        reset_n = 1'b1;
        run(5, 0, 0);
        // full song region: index wrap acts as end marker
        cyc(1, 0, 0, 0, 3); run(NS * (3 + (1 + GAP_TICKS) * TD) + 10, 0, 3);
        // randomized control on random song 1 content
        for (int r = 0; r < 6; r++) begin
            cyc(0, 1, 0, 0, 0); run(2, 0, 0);
            fill_song1();
            for (int c = 0; c < 600; c++) begin
                bit st, sp, pa;
                st = ($urandom_range(0, 59) == 0);
                sp = ($urandom_range(0, 399) == 0);
                pa = ($urandom_range(0, 9) < 2);
                cyc(st, sp, pa, r[0], 2'($urandom_range(0, 2)));
            end
        end
        cyc(0, 1, 0, 0, 0); run(3, 0, 0);
        @(negedge clk); @(negedge clk);
        n_vec++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
